// File: rtl/imem_ctrl_if.sv
// imem_ctrl_if: fetch port and byte-stream program-load port of the instruction memory controller.
interface imem_ctrl_if;
    logic        fetch_en;
    logic [31:0] pc;
    logic [31:0] imem_q;
    logic        ld_start;
    logic [15:0] ld_len;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    modport master (
        output fetch_en, pc, ld_start, ld_len, ld_byte, ld_valid,
        input  imem_q, ld_ready, ld_busy, ld_done
    );
    modport slave (
        input  fetch_en, pc, ld_start, ld_len, ld_byte, ld_valid,
        output imem_q, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory with registered fetch port and a byte-serial program loader.
module imem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input logic       clk,
    input logic       rst,
    imem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    state_t      state_q, state_d;
    logic [AW:0] len_q, len_d, word_cnt_q, word_cnt_d, len_in;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d, rdata_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic        busy, out_of_range, unused_pc;
    assign busy         = state_q != IDLE;
    assign out_of_range = |bus.pc[31:AW+2];
    assign unused_pc    = ^bus.pc[1:0];
    assign len_in       = (32'(bus.ld_len) >= DEPTH_WORDS) ? (AW+1)'(DEPTH_WORDS) : (AW+1)'(bus.ld_len);
    assign bus.imem_q   = rdata_q;
    assign bus.ld_ready = state_q == RECV;
    assign bus.ld_busy  = busy;
    assign bus.ld_done  = state_q == DONE;
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        case (state_q)
            IDLE: if (bus.ld_start) begin
                len_d      = len_in;
                word_cnt_d = '0;
                byte_cnt_d = '0;
                state_d    = (len_in == '0) ? DONE : RECV;
            end
            RECV: if (bus.ld_valid) begin
                word_d[{byte_cnt_q, 3'b000} +: 8] = bus.ld_byte;
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = (byte_cnt_q == 2'd3) ? WRITE : RECV;
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d == len_q) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end
    // Read register sits directly on the array so it maps onto the RAM output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (busy)
            rdata_q <= '0;
        else if (bus.fetch_en)
            rdata_q <= out_of_range ? '0 : mem[bus.pc[AW+1:2]];
    end
    always_ff @(posedge clk) begin
        if (state_q == WRITE)
            mem[word_cnt_q[AW-1:0]] <= word_q;
    end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: randomized loads and fetches checked against a word-array model of the memory.
module tb_imem_ctrl;
    localparam int DEPTH = 1024;
    logic clk = 0;
    logic rst;
    imem_ctrl_if bus();
    imem_ctrl #(.DEPTH_WORDS(DEPTH), .AW(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] load_words [DEPTH];
    logic [31:0] saved [DEPTH];
    logic [31:0] last_q;
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    endtask
    task automatic do_load(input int n, input bit thr, input bit xs, input int stop_at);
        int eff;
        int nb;
        eff = (n > DEPTH) ? DEPTH : n;
        nb = 0;
        bus.ld_start = 1;
        bus.ld_len = 16'(n);
        @(negedge clk);
        bus.ld_start = 0;
        if (eff == 0) begin
            chk("done_len0", 32'(bus.ld_done), 1);
            chk("busy_len0", 32'(bus.ld_busy), 1);
            @(negedge clk);
            chk("done_end_len0", 32'(bus.ld_done), 0);
            chk("idle_len0", 32'(bus.ld_busy), 0);
            return;
        end
        for (int w = 0; w < eff; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (nb == stop_at) return;
                if (thr) begin
                    bus.ld_valid = 0;
                    @(negedge clk);
                    chk("gap_ready", 32'(bus.ld_ready), 1);
                end
                chk("recv_ready", 32'(bus.ld_ready), 1);
                bus.ld_valid = 1;
                bus.ld_byte = load_words[w][8*b +: 8];
                if (xs && w == 0 && b == 1) begin
                    bus.ld_start = 1;
                    bus.ld_len = 16'd1;
                end
                @(negedge clk);
                bus.ld_valid = 0;
                bus.ld_start = 0;
                nb++;
            end
            chk("write_ready", 32'(bus.ld_ready), 0);
            chk("write_busy", 32'(bus.ld_busy), 1);
            chk("busy_imem_q", bus.imem_q, 0);
            @(negedge clk);
            ref_mem[w] = load_words[w];
        end
        chk("done_pulse", 32'(bus.ld_done), 1);
        chk("done_ready", 32'(bus.ld_ready), 0);
        @(negedge clk);
        chk("done_once", 32'(bus.ld_done), 0);
        chk("busy_fall", 32'(bus.ld_busy), 0);
        last_q = 0;
    endtask
    task automatic fetch(input logic [31:0] a);
        logic [31:0] e;
        bus.fetch_en = 1;
        bus.pc = a;
        @(negedge clk);
        e = (a[31:12] != 0) ? 32'h0 : ref_mem[a[11:2]];
        chk("fetch", bus.imem_q, e);
        last_q = e;
    endtask
    task automatic hold_check();
        bus.fetch_en = 0;
        bus.pc = $urandom;
        @(negedge clk);
        chk("hold", bus.imem_q, last_q);
    endtask
    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) load_words[i] = $urandom;
    endtask
    initial begin
        rst = 1;
        bus.fetch_en = 0; bus.pc = 0; bus.ld_start = 0; bus.ld_len = 0;
        bus.ld_byte = 0; bus.ld_valid = 0;
        last_q = 0;
        repeat (2) @(negedge clk);
        chk("rst_imem_q", bus.imem_q, 0);
        chk("rst_busy", 32'(bus.ld_busy), 0);
        chk("rst_ready", 32'(bus.ld_ready), 0);
        chk("rst_done", 32'(bus.ld_done), 0);
        rst = 0;
        @(negedge clk);
        load_words[0] = 32'h00000013;
        load_words[1] = 32'h00100093;
        do_load(2, 0, 0, -1);
        fetch(32'h4);
        fetch(32'h6);
        fetch(32'h0);
        fetch(32'h00001000);
        hold_check();
        fetch(32'h4);
        hold_check();
        hold_check();
        do_load(0, 0, 0, -1);
        fetch(32'h0);
        fetch(32'h4);
        rand_words(3);
        for (int i = 0; i < 3; i++) saved[i] = load_words[i];
        do_load(3, 0, 0, -1);
        for (int i = 0; i < 3; i++) fetch(32'(i * 4));
        rand_words(3);
        do_load(3, 0, 0, -1);
        for (int i = 0; i < 3; i++) load_words[i] = saved[i];
        do_load(3, 1, 1, -1);
        for (int i = 0; i < 3; i++) fetch(32'(i * 4) | 32'($urandom_range(0, 3)));
        rand_words(2);
        do_load(2, 0, 0, 6);
        rst = 1;
        #1;
        chk("midrst_busy", 32'(bus.ld_busy), 0);
        chk("midrst_ready", 32'(bus.ld_ready), 0);
        chk("midrst_imem_q", bus.imem_q, 0);
        @(negedge clk);
        rst = 0;
        bus.ld_valid = 0;
        @(negedge clk);
        chk("midrst_idle", 32'(bus.ld_busy), 0);
        fetch(32'h0);
        fetch(32'h4);
        rand_words(DEPTH);
        do_load(2000, 0, 0, -1);
        fetch(32'h0);
        fetch(32'(4 * (DEPTH - 1)));
        for (int i = 0; i < 40; i++) fetch($urandom_range(0, 4 * DEPTH - 1));
        for (int it = 0; it < 10; it++) begin
            int n;
            n = $urandom_range(1, 12);
            rand_words(n);
            do_load(n, 1'($urandom), 0, -1);
            for (int k = 0; k < 6; k++) fetch(32'($urandom_range(0, 4 * n - 1)));
            fetch({20'($urandom_range(1, 1 << 19)), 12'($urandom)});
            hold_check();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning instruction memory depth in 32-bit words (power of two, ≥4).
REQ-002 SHALL have parameter AW, default 10, meaning word-address width, equal to log2(DEPTH_WORDS).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-high reset.
REQ-005 SHALL have port fetch_en  input  1  meaning fetch read enable; the core drives it as the inverse of its stall.
REQ-006 SHALL have port pc  input  32  meaning the byte fetch address from the IF stage.
REQ-007 SHALL have port imem_q  output  32  meaning the registered instruction word returned to the IF stage.
REQ-008 SHALL have port ld_start  input  1  meaning a one-cycle pulse requesting a program load.
REQ-009 SHALL have port ld_len  input  16  meaning the number of words to load, sampled on an accepted ld_start.
REQ-010 SHALL have port ld_byte  input  8  meaning the program byte stream, least-significant byte of each word first.
REQ-011 SHALL have port ld_valid  input  1  meaning ld_byte is valid this cycle.
REQ-012 SHALL have port ld_ready  output  1  meaning the block accepts ld_byte this cycle.
REQ-013 SHALL have port ld_busy  output  1  meaning a load is in progress; also used as the core stall/hold request.
REQ-014 SHALL have port ld_done  output  1  meaning a one-cycle pulse marking load completion.

Function
REQ-015 SHALL hold a DEPTH_WORDS x 32 memory with synchronous read and write, inferable as block RAM, and with no reset of its contents.
REQ-016 SHALL use the word index pc[AW+1:2] for fetch and ignore pc[1:0].
REQ-017 SHALL, on each edge where fetch_en=1 and ld_busy=0, load imem_q with mem[pc[AW+1:2]], giving one cycle of read latency.
REQ-018 SHALL load imem_q with 0 (NOP) on that edge when pc[31:AW+2] is nonzero (out of range).
REQ-019 SHALL hold imem_q when fetch_en=0 and ld_busy=0.
REQ-020 SHALL drive imem_q to 0 on every edge while ld_busy=1.
REQ-021 SHALL implement the load FSM states IDLE, RECV, WRITE and DONE.
REQ-022 SHALL, in IDLE, on ld_start=1: latch len=min(ld_len, DEPTH_WORDS), clear word_cnt and byte_cnt, and go to RECV, or go directly to DONE if len=0.
REQ-023 SHALL drive ld_ready=1 only in RECV; a byte is accepted when ld_valid and ld_ready are both 1.
REQ-024 SHALL place the accepted byte into word-assembly bits [8*byte_cnt+7 : 8*byte_cnt].
REQ-025 SHALL increment byte_cnt (2 bits, wrapping) on each accepted byte.
REQ-026 SHALL move from RECV to WRITE when the 4th byte (byte_cnt=3) is accepted.
REQ-027 SHALL, in WRITE (exactly one cycle), write the assembled word to mem[word_cnt] and increment word_cnt.
REQ-028 SHALL, leaving WRITE, go to DONE if word_cnt+1=len, otherwise return to RECV.
REQ-029 SHALL hold DONE for exactly one cycle with ld_done=1, then return to IDLE.
REQ-030 SHALL drive ld_busy=1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-031 SHALL ignore ld_start outside IDLE.
REQ-032 SHALL treat ld_valid gaps (ld_valid=0 in RECV) as a wait, with no state change and no timeout.
REQ-033 SHALL size word_cnt to AW+1 bits so that len=DEPTH_WORDS completes without wrapping.

Reset
REQ-034 SHALL, on rst=1, asynchronously force FSM=IDLE, imem_q=0, word_cnt=0, byte_cnt=0, ld_ready=0, ld_busy=0 and ld_done=0.
REQ-035 SHALL leave memory contents unchanged by reset, including a reset during RECV or WRITE; words already written are retained and a partial word is discarded.

Verification
REQ-036 SHALL verify a basic load: ld_start with ld_len=2, then bytes 13,00,00,00,93,00,10,00 sent back-to-back -> mem[0]=0x00000013, mem[1]=0x00100093, ld_ready low for one cycle after every 4th byte, ld_done pulses once, ld_busy falls on the cycle after DONE.
REQ-037 SHALL verify fetch after load: fetch_en=1 with pc=0x4, 0x6 and 0x0 on successive edges -> imem_q=0x00100093, 0x00100093, 0x00000013, each one cycle after its pc.
REQ-038 SHALL verify out-of-range fetch: with DEPTH_WORDS=1024, pc=0x00001000 -> imem_q=0; fetch_en=0 -> imem_q holds its prior value.
REQ-039 SHALL verify boundary lengths: ld_len=0 -> DONE on the next edge with one ld_done pulse and no write; ld_len=2000 -> exactly 1024 words written, then ld_done.
REQ-040 SHALL verify reset mid-load: rst asserted after 6 of 8 bytes -> FSM=IDLE and ld_busy=0 immediately, mem[0] retained, mem[1] unchanged.
REQ-041 SHALL verify ignored start and throttled input: a second ld_start during RECV has no effect; ld_valid toggling every other cycle still assembles the same words as back-to-back delivery.
